// File: rtl/msx_bus_arbiter.sv
// Purpose : round-robin owner selection for the shared MSX system bus, Z80 CPU is requester 0,
//           with a turnaround gap between owners and WAIT_n generation for a stalled CPU.
// Latency : req -> gnt 1 cycle from IDLE; release -> next grant 1 + TURNAROUND + 1 cycles.
// Backpressure: requesters hold req until granted and done; CPU is stalled via wait_n while waiting.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   req[REQ_N]        per-master bus request, held until granted and done
//   done[REQ_N]       1-cycle release pulse, only the current owner's bit is honoured
//   gnt[REQ_N]        registered one-hot grant
//   owner             index of current / last owner
//   busy              high while any grant is high
//   wait_n            Z80 WAIT_n, low while req[0] is up and gnt[0] is not
//   timeout_err       1-cycle pulse on a forced release
//
// Optional feature: define ARB_TIMEOUT_EN to force release after TIMEOUT owned cycles.
// Without it timeout_err is tied low and an owner may hold the bus indefinitely.

module msx_bus_arbiter #(
    parameter int REQ_N      = 3,
    parameter int TURNAROUND = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REQ_N-1:0]         req,
    input  logic [REQ_N-1:0]         done,
    output logic [REQ_N-1:0]         gnt,
    output logic [$clog2(REQ_N)-1:0] owner,
    output logic                     busy,
    output logic                     wait_n,
    output logic                     timeout_err
);

    localparam int OW = $clog2(REQ_N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_TURN = 2'd2;

    logic [1:0]    state;
    logic [OW-1:0] ptr;
    logic [3:0]    turn_cnt;

    logic [OW-1:0] sel;
    logic          sel_vld;
    int            idx;

    logic          nat_release;
    logic          force_release;
    logic          release_now;
    logic [OW-1:0] next_ptr;

    // Round-robin pick: walk from the highest offset down so the last hit,
    // i.e. the requester closest to ptr, wins.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= REQ_N) begin
                idx = idx - REQ_N;
            end
            if (req[idx[OW-1:0]]) begin
                sel     = idx[OW-1:0];
                sel_vld = 1'b1;
            end
        end
    end

    // A done pulse and a dropped request in the same cycle are one release.
    assign nat_release = done[owner] | ~req[owner];
    assign release_now = (state == ST_OWN) & (nat_release | force_release);
    assign next_ptr    = (owner == OW'(REQ_N - 1)) ? '0 : owner + 1'b1;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // hold_cnt equals the number of OWN cycles already completed, so the
    // release is forced during the TIMEOUT-th owned cycle.
    assign force_release = (state == ST_OWN) & (hold_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= (state == ST_OWN) & force_release & ~nat_release;
            if (state == ST_IDLE) begin
                hold_cnt <= '0;
            end else if (state == ST_OWN) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign force_release = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_vld) begin
                        gnt   <= {{(REQ_N-1){1'b0}}, 1'b1} << sel;
                        owner <= sel;
                        busy  <= 1'b1;
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (release_now) begin
                        gnt      <= '0;
                        busy     <= 1'b0;
                        ptr      <= next_ptr;
                        turn_cnt <= 4'(TURNAROUND - 1);
                        state    <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (turn_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Combinational so the CPU is stalled in the very cycle it requests;
    // held inactive during reset.
    assign wait_n = rst_n ? ~(req[0] & ~gnt[0]) : 1'b1;

endmodule
